dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line: DataWidth, 32, data bus width; AddrWidth, 15, word address width; MemLatency, 1, cycles from mem_en to valid mem_rdata (legal 1..4).
REQ-002 brq_clk  in  1  sole clock, all state updates on rising edge.
REQ-003 brq_rst  in  1  synchronous, active-high reset.
REQ-004 core_req / core_we  in  1/1  core load-store request / write qualifier.
REQ-005 core_addr  in  AddrWidth  word address; core_byte_en  in  3  lane code; core_wdata  in  DataWidth  store data.
REQ-006 core_gnt / core_rvalid  out  1/1  access accepted / response valid; core_rdata  out  DataWidth  read data.
REQ-007 core_stall  out  1  freeze request to the core pipeline.
REQ-008 ext_req, ext_we, ext_addr, ext_byte_en, ext_wdata, ext_gnt, ext_rvalid, ext_rdata: same widths and meaning as the core_ set, for the external (debug/boot-load) requester.
REQ-009 mem_en, mem_we  out  1/1; mem_addr  out  AddrWidth; mem_byte_en  out  3; mem_wdata  out  DataWidth; mem_rdata  in  DataWidth.

Function
REQ-010 FSM states: IDLE, BUSY; owner register (CORE/EXT); latency counter cnt, 2 bits.
REQ-011 IDLE with at least one req: the arbiter shall select a winner, assert winner's gnt and mem_en combinationally in that cycle, drive mem_* from the winner's inputs, record owner, load cnt=MemLatency-1, and go to BUSY.
REQ-012 Winner selection without ROUND_ROBIN_EN: core wins any tie.
REQ-013 BUSY: mem_en=0, both gnt=0, cnt decrements each cycle; rvalid is asserted to owner only, exactly MemLatency cycles after the grant cycle, for one cycle.
REQ-014 On the rvalid cycle, owner rdata shall equal mem_rdata (combinational pass-through), rvalid asserted for writes too (acknowledge), and FSM returns to IDLE.
REQ-015 At most one access outstanding; a new grant may not occur before the cycle following the rvalid (grant-to-grant spacing MemLatency+1 cycles).
REQ-016 Non-owner rdata shall read 0; rvalid never asserted to a non-owner.
REQ-017 A req deasserted before gnt is dropped without memory side effects; req sampled only in IDLE.
REQ-018 core_stall = (core_req and not core_gnt) or (BUSY and owner=CORE and not core_rvalid).
REQ-019 mem_we = winner's we and mem_en; mem_* other outputs shall be 0 when mem_en=0.

Reset
REQ-020 On brq_rst: FSM=IDLE, owner=CORE, cnt=0, last-winner=EXT; all gnt, rvalid, mem_en, mem_we, core_stall low the following cycle.
REQ-021 Reset mid-access shall abort the outstanding access: no rvalid is ever issued for it.
REQ-022 Requests present during reset shall not be granted in the reset cycle.

Configuration
REQ-023 Macro DMEM_ARB_ROUND_ROBIN_EN: when defined, a last-winner register shall exist and ties go to the requester that did not win the previous grant; when undefined, fixed core priority (REQ-012) and no last-winner register.

Verification
REQ-024 MemLatency=1, core_req read addr 0x0004, mem_rdata=0xDEADBEEF -> core_gnt cycle N, core_rvalid cycle N+1 with core_rdata 0xDEADBEEF, ext_rvalid 0.
REQ-025 MemLatency=3, ext_req write addr 0x0010 data 0x12345678 byte_en 3'b110 -> mem_en/mem_we high one cycle with those values, ext_rvalid exactly 3 cycles later, core_stall 0.
REQ-026 Both req held high continuously, macro undefined -> grants all CORE; macro defined -> grants alternate CORE, EXT, CORE, EXT, spaced MemLatency+1 cycles.
REQ-027 ext owns access, core_req rises in BUSY -> core_stall 1 until core_gnt in the cycle after ext_rvalid.
REQ-028 MemLatency=2, brq_rst asserted the cycle after core_gnt -> no core_rvalid ever issued, all outputs 0, next core_req granted normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: grants one of two requesters (core, ext) a fixed-latency data memory.
// Optional macro DMEM_ARB_ROUND_ROBIN_EN: ties go to whoever lost the previous grant.
module dmem_arbiter #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 15,
  parameter int MemLatency = 1
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic                 core_req,
  input  logic                 core_we,
  input  logic [AddrWidth-1:0] core_addr,
  input  logic [2:0]           core_byte_en,
  input  logic [DataWidth-1:0] core_wdata,
  output logic                 core_gnt,
  output logic                 core_rvalid,
  output logic [DataWidth-1:0] core_rdata,
  output logic                 core_stall,
  input  logic                 ext_req,
  input  logic                 ext_we,
  input  logic [AddrWidth-1:0] ext_addr,
  input  logic [2:0]           ext_byte_en,
  input  logic [DataWidth-1:0] ext_wdata,
  output logic                 ext_gnt,
  output logic                 ext_rvalid,
  output logic [DataWidth-1:0] ext_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [2:0]           mem_byte_en,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic [DataWidth-1:0] mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic {OWN_CORE, OWN_EXT} owner_e;

  localparam logic [1:0] CntInit = 2'(MemLatency - 1);

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [1:0] cnt_q, cnt_d;

  logic any_req;
  logic pick_ext;
  logic grant;
  logic rsp;

  assign any_req = core_req | ext_req;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  owner_e last_q, last_d;

  // Tie goes to the requester that did not win last time.
  assign pick_ext = !core_req |
                    (ext_req & (last_q == OWN_CORE));
  assign last_d   = grant ? owner_d : last_q;
`else
  // Fixed priority: core wins every tie.
  assign pick_ext = !core_req;
`endif

  // Grants only from IDLE and never while reset is held.
  assign grant = (state_q == IDLE) & any_req & !brq_rst;
  assign rsp   = (state_q == BUSY) & (cnt_q == 2'd0) & !brq_rst;

  assign core_gnt = grant & !pick_ext;
  assign ext_gnt  = grant & pick_ext;

  assign mem_en      = grant;
  assign mem_we      = grant & (pick_ext ? ext_we : core_we);
  assign mem_addr    = !grant ? '0 :
                       (pick_ext ? ext_addr : core_addr);
  assign mem_byte_en = !grant ? '0 :
                       (pick_ext ? ext_byte_en : core_byte_en);
  assign mem_wdata   = !grant ? '0 :
                       (pick_ext ? ext_wdata : core_wdata);

  assign core_rvalid = rsp & (owner_q == OWN_CORE);
  assign ext_rvalid  = rsp & (owner_q == OWN_EXT);
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign ext_rdata   = ext_rvalid ? mem_rdata : '0;

  assign core_stall = !brq_rst &
                      ((core_req & !core_gnt) |
                       ((state_q == BUSY) &
                        (owner_q == OWN_CORE) &
                        !core_rvalid));

  // Next state: latch owner and latency on grant, count down while busy.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = BUSY;
          owner_d = pick_ext ? OWN_EXT : OWN_CORE;
          cnt_d   = CntInit;
        end
      end
      BUSY: begin
        if (cnt_q == 2'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
    endcase
  end

  // State registers; reset drops any access in flight.
  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      state_q <= IDLE;
      owner_q <= OWN_CORE;
      cnt_q   <= 2'd0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q  <= OWN_EXT;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: three arbiters (MemLatency 1,2,3) driven by directed vectors;
// grant/response events are checked by a per-instance scoreboard monitor.
module tb_dmem_arbiter;

  typedef struct {
    bit          kind;
    bit          port;
    int          cyc;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        core_req[3], core_we[3], ext_req[3], ext_we[3];
  logic [14:0] core_addr[3], ext_addr[3], mem_addr[3];
  logic [2:0]  core_be[3], ext_be[3], mem_be[3];
  logic [31:0] core_wdata[3], ext_wdata[3], mem_wdata[3];
  logic [31:0] mem_rdata[3], core_rdata[3], ext_rdata[3];
  logic        core_gnt[3], core_rvalid[3], core_stall[3];
  logic        ext_gnt[3], ext_rvalid[3], mem_en[3], mem_we[3];

  ev_t q[3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_arbiter #(
      .DataWidth (32),
      .AddrWidth (15),
      .MemLatency(g + 1)
    ) u_dut (
      .brq_clk     (clk),
      .brq_rst     (rst),
      .core_req    (core_req[g]),
      .core_we     (core_we[g]),
      .core_addr   (core_addr[g]),
      .core_byte_en(core_be[g]),
      .core_wdata  (core_wdata[g]),
      .core_gnt    (core_gnt[g]),
      .core_rvalid (core_rvalid[g]),
      .core_rdata  (core_rdata[g]),
      .core_stall  (core_stall[g]),
      .ext_req     (ext_req[g]),
      .ext_we      (ext_we[g]),
      .ext_addr    (ext_addr[g]),
      .ext_byte_en (ext_be[g]),
      .ext_wdata   (ext_wdata[g]),
      .ext_gnt     (ext_gnt[g]),
      .ext_rvalid  (ext_rvalid[g]),
      .ext_rdata   (ext_rdata[g]),
      .mem_en      (mem_en[g]),
      .mem_we      (mem_we[g]),
      .mem_addr    (mem_addr[g]),
      .mem_byte_en (mem_be[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_rdata   (mem_rdata[g])
    );
  end

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, got, exp);
    end
  endtask

  task automatic push(input int d, input bit kind, input bit port,
                      input int c, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.port = port;
    e.cyc  = c;
    e.data = data;
    q[d].push_back(e);
  endtask

  task automatic observe(input int d, input bit kind, input bit port,
                         input logic [31:0] data);
    ev_t e;
    checks++;
    if (q[d].size() == 0) begin
      errors++;
      $display("FAIL unexpected_event dut%0d kind=%0d port=%0d cyc=%0d",
               d, kind, port, cyc);
    end else begin
      e = q[d].pop_front();
      if (e.kind != kind || e.port != port || e.cyc != cyc ||
          (kind && e.data !== data)) begin
        errors++;
        $display("FAIL event dut%0d got k%0d p%0d c%0d d=%h want k%0d p%0d c%0d d=%h",
                 d, kind, port, cyc, data, e.kind, e.port, e.cyc, e.data);
      end
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_mon
    always @(negedge clk) begin
      if (core_gnt[g]) observe(g, 1'b0, 1'b0, 32'h0);
      if (ext_gnt[g]) observe(g, 1'b0, 1'b1, 32'h0);
      if (core_rvalid[g]) begin
        observe(g, 1'b1, 1'b0, core_rdata[g]);
        chk("nonowner_ext_rdata", ext_rdata[g], 32'h0);
      end
      if (ext_rvalid[g]) begin
        observe(g, 1'b1, 1'b1, ext_rdata[g]);
        chk("nonowner_core_rdata", core_rdata[g], 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] ctl(input int d);
    return {core_gnt[d], ext_gnt[d], core_rvalid[d], ext_rvalid[d],
            mem_en[d], mem_we[d], core_stall[d]};
  endfunction

  // Single access on instance d; call right after a rising edge while idle.
  task automatic access(input int d, input bit port, input bit we,
                        input logic [14:0] a, input logic [2:0] be,
                        input logic [31:0] wd, input logic [31:0] rd);
    int c;
    int lat;
    c = cyc;
    lat = d + 1;
    mem_rdata[d] = rd;
    if (port) begin
      ext_req[d] = 1'b1; ext_we[d] = we; ext_addr[d] = a;
      ext_be[d] = be; ext_wdata[d] = wd;
    end else begin
      core_req[d] = 1'b1; core_we[d] = we; core_addr[d] = a;
      core_be[d] = be; core_wdata[d] = wd;
    end
    push(d, 1'b0, port, c, 32'h0);
    push(d, 1'b1, port, c + lat, rd);
    @(negedge clk);
    chk("mem_en", mem_en[d], 1);
    chk("mem_we", mem_we[d], we);
    chk("mem_addr", mem_addr[d], a);
    chk("mem_byte_en", mem_be[d], be);
    chk("mem_wdata", mem_wdata[d], wd);
    chk("stall_gnt", core_stall[d], 0);
    step();
    core_req[d] = 1'b0;
    ext_req[d]  = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk("mem_idle", {mem_en[d], mem_we[d], mem_addr[d], mem_wdata[d][15:0]}, 0);
      chk("stall_busy", core_stall[d], (!port && i < lat) ? 1 : 0);
      step();
    end
  endtask

  initial begin
    int c;
    bit p;
    logic [6:0] st_exp[7];
    for (int d = 0; d < 3; d++) begin
      core_req[d] = 0; core_we[d] = 0; core_addr[d] = 0;
      core_be[d] = 0; core_wdata[d] = 0;
      ext_req[d] = 0; ext_we[d] = 0; ext_addr[d] = 0;
      ext_be[d] = 0; ext_wdata[d] = 0; mem_rdata[d] = 0;
    end
    rst = 1'b1;
    step();
    core_req[0] = 1'b1;
    ext_req[2]  = 1'b1;
    @(negedge clk);
    chk("no_gnt_in_reset0", {core_gnt[0], mem_en[0]}, 0);
    chk("no_gnt_in_reset2", {ext_gnt[2], mem_en[2]}, 0);
    step();
    core_req[0] = 1'b0;
    ext_req[2]  = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk("reset_ctl", ctl(d), 0);
    step();

    // Core read, latency 1.
    access(0, 1'b0, 1'b0, 15'h0004, 3'b111, 32'h0, 32'hDEADBEEF);
    // Ext write, latency 3.
    access(2, 1'b1, 1'b1, 15'h0010, 3'b110, 32'h12345678, 32'h0000_5A5A);
    // Core write, latency 2.
    access(1, 1'b0, 1'b1, 15'h7FFF, 3'b001, 32'hCAFE_0001, 32'h1111_2222);

    // Both requesters held high on latency 2.
    c = cyc;
    mem_rdata[1] = 32'hA5A5_0001;
    core_req[1] = 1'b1;
    ext_req[1]  = 1'b1;
    ext_we[1]   = 1'b1;
    for (int k = 0; k < 3; k++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      p = k[0];
`else
      p = 1'b0;
`endif
      push(1, 1'b0, p, c + 3 * k, 32'h0);
      push(1, 1'b1, p, c + 3 * k + 2, 32'hA5A5_0001);
    end
    repeat (7) step();
    core_req[1] = 1'b0;
    ext_req[1]  = 1'b0;
    ext_we[1]   = 1'b0;
    repeat (2) step();

    // Ext owns, core arrives while busy, latency 3.
    st_exp = '{1, 1, 1, 0, 1, 1, 0};
    c = cyc;
    mem_rdata[2] = 32'h0BAD_F00D;
    ext_req[2] = 1'b1;
    ext_addr[2] = 15'h0020;
    core_addr[2] = 15'h0030;
    push(2, 1'b0, 1'b1, c, 32'h0);
    push(2, 1'b1, 1'b1, c + 3, 32'h0BAD_F00D);
    push(2, 1'b0, 1'b0, c + 4, 32'h0);
    push(2, 1'b1, 1'b0, c + 7, 32'h0BAD_F00D);
    @(negedge clk);
    chk("stall_ext_gnt", core_stall[2], 0);
    step();
    ext_req[2]  = 1'b0;
    core_req[2] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      if (i == 5) core_req[2] = 1'b0;
      @(negedge clk);
      chk("stall_contend", core_stall[2], st_exp[i - 1]);
      step();
    end

    // Reset mid-access on latency 2; request held through reset.
    c = cyc;
    mem_rdata[1] = 32'h7777_0001;
    core_req[1] = 1'b1;
    core_addr[1] = 15'h0044;
    push(1, 1'b0, 1'b0, c, 32'h0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ctl", ctl(1), 0);
    chk("abort_addr", mem_addr[1], 0);
    step();
    rst = 1'b0;
    push(1, 1'b0, 1'b0, c + 2, 32'h0);
    push(1, 1'b1, 1'b0, c + 4, 32'h7777_0001);
    @(negedge clk);
    chk("regrant_en", mem_en[1], 1);
    chk("regrant_addr", mem_addr[1], 15'h0044);
    step();
    core_req[1] = 1'b0;
    repeat (3) step();

    for (int d = 0; d < 3; d++) begin
      checks++;
      if (q[d].size() != 0) begin
        errors++;
        $display("FAIL missing_events dut%0d got=0 want=%0d", d, q[d].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
